// File: rtl/t1_tb_idle_tracker_pkg.sv
// ---------------------------------------------------------------------------
// t1_idle_pkg
//   Shared types and width helpers for the idle tracker.
//   - state_e : tracker FSM states (2 bits)
//   - tot_w() : width of the registered outstanding-transaction sum
// ---------------------------------------------------------------------------
package t1_idle_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        QUIET = 2'd2,
        IDLE  = 2'd3
    } state_e;

    // The sum of NUM_PORTS counters of CNT_W bits, plus one spare bit so
    // the total can never wrap even when every port is saturated.
    function automatic int tot_w(input int cnt_w, input int num_ports);
        return cnt_w + $clog2(num_ports) + 1;
    endfunction

    localparam int DEF_TOT_W = 8 + 2 + 1; // tot_w(8, 3)

endpackage

// File: rtl/t1_tb_idle_tracker_if.sv
// ---------------------------------------------------------------------------
// t1_tb_idle_tracker_if
//   Bundles the tracker's traffic observation inputs, quit handshake and
//   status outputs.
//   master : environment side (drives fires/quit/limit, reads status)
//   slave  : tracker side
//   Signals:
//     req_fire[NUM_PORTS]  AR/AW accepted this cycle, per port
//     rsp_fire[NUM_PORTS]  R-last/B accepted this cycle, per port
//     quit_req             cosim quit request (level or pulse)
//     drain_limit          DRAIN+QUIET cycle budget, 0 = unchecked
//     idle                 all ports drained and quiet
//     outstanding_total    sum of per-port outstanding counts
//     err_underflow / err_overflow / err_late_req / drain_timeout  sticky
// ---------------------------------------------------------------------------
interface t1_tb_idle_tracker_if #(
    parameter int NUM_PORTS = 3,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT_W = 32
);
    import t1_idle_pkg::*;

    localparam int TOT_W = tot_w(CNT_W, NUM_PORTS);

    logic [NUM_PORTS-1:0] req_fire;
    logic [NUM_PORTS-1:0] rsp_fire;
    logic                 quit_req;
    logic [TIMEOUT_W-1:0] drain_limit;
    logic                 idle;
    logic [TOT_W-1:0]     outstanding_total;
    logic                 err_underflow;
    logic                 err_overflow;
    logic                 err_late_req;
    logic                 drain_timeout;

    modport master (
        output req_fire, rsp_fire, quit_req, drain_limit,
        input  idle, outstanding_total, err_underflow, err_overflow,
               err_late_req, drain_timeout
    );

    modport slave (
        input  req_fire, rsp_fire, quit_req, drain_limit,
        output idle, outstanding_total, err_underflow, err_overflow,
               err_late_req, drain_timeout
    );

endinterface

// File: rtl/t1_tb_idle_tracker_counter.sv
// ---------------------------------------------------------------------------
// t1_outstanding_counter
//   Saturating up/down counter of in-flight transactions for one port.
//   Ports:
//     clock, reset_n   clock, async active-low reset
//     req_i            request accepted (+1)
//     rsp_i            response completed (-1)
//     cnt_o            current count
//     cnt_d_o          count after the coming edge
//     ovf_o            pulse: req alone while saturated (count held)
//     udf_o            pulse: rsp alone while empty (count held at 0)
// ---------------------------------------------------------------------------
module t1_outstanding_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_i,
    input  logic             rsp_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic             ovf_o,
    output logic             udf_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous req+rsp cancel out, so they never raise an error even
    // at the saturation bounds.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        udf_o = 1'b0;
        if (req_i && !rsp_i) begin
            if (&cnt_q) ovf_o = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
        end else if (rsp_i && !req_i) begin
            if (cnt_q == '0) udf_o = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/t1_tb_idle_tracker.sv
// ---------------------------------------------------------------------------
// t1_tb_idle_tracker
//   Tracks outstanding AXI transactions on the memory ports and answers the
//   sim-control quit handshake: after quit_req, idle rises once every port
//   has drained and the traffic has stayed quiet for QUIET_CYCLES edges.
//   Protocol anomalies and drain timeouts are reported as sticky flags.
//   Ports:
//     clock     sole clock
//     reset_n   async active-low reset
//     bus       t1_tb_idle_tracker_if slave modport (fires, quit, status)
// ---------------------------------------------------------------------------
module t1_tb_idle_tracker
    import t1_idle_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int CNT_W        = 8,
    parameter int QUIET_CYCLES = 16,
    parameter int TIMEOUT_W    = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    t1_tb_idle_tracker_if.slave   bus
);
    localparam int TOT_W = tot_w(CNT_W, NUM_PORTS);
    localparam int QW    = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

    // ---------------- per-port counters ----------------
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_PORTS-1:0]            ovf;
    logic [NUM_PORTS-1:0]            udf;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        t1_outstanding_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .req_i   (bus.req_fire[p]),
            .rsp_i   (bus.rsp_fire[p]),
            .cnt_o   (cnt[p]),
            .cnt_d_o (cnt_d[p]),
            .ovf_o   (ovf[p]),
            .udf_o   (udf[p])
        );
    end

    // ---------------- quiet detection ----------------
    logic all_zero;
    logic any_fire;
    logic quiet;

    always_comb begin
        all_zero = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++)
            if (cnt[p] != '0) all_zero = 1'b0;
    end

    assign any_fire = (|bus.req_fire) | (|bus.rsp_fire);
    assign quiet    = all_zero & ~any_fire;

    // ---------------- FSM ----------------
    state_e          state_q, state_d;
    logic [QW-1:0]   quiet_cnt_q, quiet_cnt_d;
    logic            late_req;

    always_comb begin
        state_d     = state_q;
        quiet_cnt_d = quiet_cnt_q;
        late_req    = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.quit_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (quiet) begin
                    state_d     = QUIET;
                    quiet_cnt_d = '0;
                end
            end
            QUIET: begin
                // Counters are zero on entry and only move on a fire, so
                // "not quiet" here always means some port fired.
                if (!quiet)                         state_d     = DRAIN;
                else if (quiet_cnt_q == QUIET_LAST) state_d     = IDLE;
                else                                quiet_cnt_d = quiet_cnt_q + 1'b1;
            end
            IDLE: begin
                if (|bus.req_fire) begin
                    state_d  = DRAIN;
                    late_req = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // ---------------- drain budget ----------------
    logic                 in_drain;
    logic [TIMEOUT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                 timeout_hit;

    assign in_drain = (state_q == DRAIN) || (state_q == QUIET);

    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (in_drain && !(&drain_cnt_q)) drain_cnt_d = drain_cnt_q + 1'b1;
    end

    // Compare against the post-edge count so the flag rises on the same edge
    // the budget is used up.
    assign timeout_hit = in_drain && (bus.drain_limit != '0) &&
                         (drain_cnt_d == bus.drain_limit);

    // ---------------- outstanding sum ----------------
    logic [TOT_W-1:0] total_d;

    always_comb begin
        total_d = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            total_d = total_d + TOT_W'(cnt_d[p]);
    end

    // ---------------- registers ----------------
    logic             idle_q;
    logic [TOT_W-1:0] total_q;
    logic             err_udf_q, err_ovf_q, err_late_q, timeout_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            quiet_cnt_q <= '0;
            drain_cnt_q <= '0;
            idle_q      <= 1'b0;
            total_q     <= '0;
            err_udf_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_late_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            quiet_cnt_q <= quiet_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            idle_q      <= (state_d == IDLE);
            total_q     <= total_d;
            err_udf_q   <= err_udf_q  | (|udf);
            err_ovf_q   <= err_ovf_q  | (|ovf);
            err_late_q  <= err_late_q | late_req;
            timeout_q   <= timeout_q  | timeout_hit;
        end
    end

    assign bus.idle              = idle_q;
    assign bus.outstanding_total = total_q;
    assign bus.err_underflow     = err_udf_q;
    assign bus.err_overflow      = err_ovf_q;
    assign bus.err_late_req      = err_late_q;
    assign bus.drain_timeout     = timeout_q;

endmodule

// File: tb/tb_t1_tb_idle_tracker.sv
// ---------------------------------------------------------------------------
// tb_t1_tb_idle_tracker
//   Scoreboard bench: the driver steps a behavioural model per cycle and
//   queues the expected post-edge status; a monitor pops and compares after
//   every active edge.
// ---------------------------------------------------------------------------
module tb_t1_tb_idle_tracker;
    localparam int NP    = 3;
    localparam int CW    = 2;
    localparam int QC    = 4;
    localparam int TW    = 32;
    localparam int TOT_W = CW + $clog2(NP) + 1;
    localparam int EW    = TOT_W + 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    t1_tb_idle_tracker_if #(.NUM_PORTS(NP), .CNT_W(CW), .TIMEOUT_W(TW)) bus();

    t1_tb_idle_tracker #(
        .NUM_PORTS(NP), .CNT_W(CW), .QUIET_CYCLES(QC), .TIMEOUT_W(TW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [EW-1:0] exp_q[$];

    // ---------------- behavioural model ----------------
    // mode: 0 = running, 1 = draining (waiting for quiet), 2 = idle
    int     m_cnt[NP];
    int     m_mode;
    int     m_streak;      // consecutive quiet edges while draining
    longint m_dedges;      // edges spent draining
    bit     m_uf, m_of, m_late, m_to;

    task automatic model_reset();
        foreach (m_cnt[p]) m_cnt[p] = 0;
        m_mode = 0; m_streak = 0; m_dedges = 0;
        m_uf = 0; m_of = 0; m_late = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [NP-1:0] rq, input logic [NP-1:0] rs,
                              input logic qt, input logic [TW-1:0] lim);
        int  sum = 0;
        bit  q;
        foreach (m_cnt[p]) sum += m_cnt[p];
        q = (sum == 0) && (rq == 0) && (rs == 0);
        for (int p = 0; p < NP; p++) begin
            if (rq[p] && !rs[p]) begin
                if (m_cnt[p] == CMAX) m_of = 1; else m_cnt[p]++;
            end else if (rs[p] && !rq[p]) begin
                if (m_cnt[p] == 0) m_uf = 1; else m_cnt[p]--;
            end
        end
        case (m_mode)
            0: if (qt) begin m_mode = 1; m_streak = 0; end
            1: begin
                if (m_dedges < 64'hFFFF_FFFF) m_dedges++;
                if (lim != 0 && m_dedges == longint'(lim)) m_to = 1;
                m_streak = q ? m_streak + 1 : 0;
                if (m_streak == QC + 1) m_mode = 2;
            end
            default: if (rq != 0) begin m_late = 1; m_mode = 1; m_streak = 0; end
        endcase
    endtask

    function automatic logic [EW-1:0] model_vec();
        int sum = 0;
        foreach (m_cnt[p]) sum += m_cnt[p];
        return {(m_mode == 2), TOT_W'(sum), m_uf, m_of, m_late, m_to};
    endfunction

    function automatic logic [EW-1:0] dut_vec();
        return {bus.idle, bus.outstanding_total, bus.err_underflow,
                bus.err_overflow, bus.err_late_req, bus.drain_timeout};
    endfunction

    // ---------------- driver helpers ----------------
    // Called at a falling edge; inputs apply to the next rising edge.
    task automatic cyc(input logic [NP-1:0] rq, input logic [NP-1:0] rs, input logic qt);
        bus.req_fire = rq;
        bus.rsp_fire = rs;
        bus.quit_req = qt;
        model_step(rq, rs, qt, bus.drain_limit);
        exp_q.push_back(model_vec());
        @(negedge clock);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0, 1'b0);
    endtask

    // Asserts reset between edges, checks the async clear, then releases.
    task automatic do_reset(input logic [TW-1:0] lim);
        logic [EW-1:0] a;
        #2;
        reset_n      = 1'b0;
        bus.req_fire = '0;
        bus.rsp_fire = '0;
        bus.quit_req = 1'b0;
        #1;
        a = dut_vec();
        vectors++;
        if (a !== '0) begin
            miscompares++;
            $display("FAIL async_reset t=%0t got=%b want=%b", $time, a, {EW{1'b0}});
        end
        model_reset();
        exp_q.delete();
        bus.drain_limit = lim;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e, a;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_vec();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL status t=%0t got idle=%b tot=%0d uf=%b of=%b late=%b to=%b want idle=%b tot=%0d uf=%b of=%b late=%b to=%b",
                             $time, a[EW-1], a[EW-2:4], a[3], a[2], a[1], a[0],
                             e[EW-1], e[EW-2:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NP-1:0] rq, rs;
        logic          qt;
        logic [EW-1:0] a;
        int            phase_len;
        bit            silent;

        bus.req_fire    = '0;
        bus.rsp_fire    = '0;
        bus.quit_req    = 1'b0;
        bus.drain_limit = '0;
        model_reset();

        @(negedge clock);
        a = dut_vec();
        vectors++;
        if (a !== '0) begin
            miscompares++;
            $display("FAIL reset_state got=%b want=%b", a, {EW{1'b0}});
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Quit with nothing outstanding, then a late request from IDLE.
        idle_cycles(10);
        cyc('0, '0, 1'b1);
        idle_cycles(8);
        cyc(3'b001, '0, 1'b0);
        cyc('0, 3'b001, 1'b0);
        idle_cycles(7);

        // Three requests, quit, responses spaced out.
        do_reset('0);
        repeat (3) cyc(3'b001, '0, 1'b0);
        cyc('0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc('0, 3'b001, 1'b0);
            idle_cycles(4);
        end
        idle_cycles(3);

        // Same-cycle req+rsp on an empty port, then a lone rsp.
        cyc(3'b010, 3'b010, 1'b0);
        cyc('0, 3'b010, 1'b0);

        // Saturation on port 2.
        do_reset('0);
        repeat (4) cyc(3'b100, '0, 1'b0);
        repeat (3) cyc('0, 3'b100, 1'b0);
        cyc(3'b100, 3'b100, 1'b0);

        // Drain timeout with one transaction stuck, then reset mid-run.
        do_reset(32'd20);
        cyc(3'b001, '0, 1'b0);
        cyc('0, '0, 1'b1);
        idle_cycles(25);
        do_reset('0);

        // Randomized traffic with bursts of silence so idle is reachable.
        phase_len = 0;
        silent    = 0;
        for (int i = 0; i < 4000; i++) begin
            if (phase_len == 0) begin
                phase_len = $urandom_range(5, 40);
                silent    = ($urandom_range(0, 2) == 0);
            end
            phase_len--;
            if (silent) begin
                rq = '0;
                rs = '0;
                for (int p = 0; p < NP; p++)
                    if (m_cnt[p] > 0 && $urandom_range(0, 1) == 1) rs[p] = 1'b1;
            end else begin
                rq = NP'($urandom & $urandom);
                rs = NP'($urandom & $urandom);
            end
            qt = ($urandom_range(0, 29) == 0);
            cyc(rq, rs, qt);
            if ($urandom_range(0, 399) == 0)
                do_reset(($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(5, 60)));
        end

        @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_queue left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/t1_tb_idle_tracker.md
Name: t1_tb_idle_tracker

Overview:
Synthesizable testbench-side block that produces the `idle` level consumed by the simulation-control module. It answers that module's quit handshake.
- Counts outstanding AXI transactions on every DPI-backed memory port.
- Once quit is requested, asserts idle only after all ports have drained and stayed quiet.
- Flags protocol anomalies and drain timeouts as sticky errors for the sim-control module to escalate.

Parameters:
NUM_PORTS, 3, number of tracked AXI ports (instruction fetch, scalar LSU, vector LSU)
CNT_W, 8, per-port outstanding counter width; saturates at 2^CNT_W-1
QUIET_CYCLES, 16, consecutive all-zero, no-fire cycles required before idle; must be >=1
TIMEOUT_W, 32, width of the drain timeout counter and its limit input

Ports:
clock  input  1  sole clock
reset_n  input  1  asynchronous active-low reset
req_fire  input  NUM_PORTS  per port: AR or AW handshake accepted this cycle
rsp_fire  input  NUM_PORTS  per port: R-last or B handshake accepted this cycle
quit_req  input  1  cosim has quit (level or pulse); sampled only in RUN
drain_limit  input  TIMEOUT_W  max cycles spent in DRAIN+QUIET; 0 disables the check
idle  output  1  registered; high only in state IDLE
outstanding_total  output  CNT_W+$clog2(NUM_PORTS)+1  registered sum of all port counters
err_underflow  output  1  sticky: rsp_fire seen on a port whose count is 0
err_overflow  output  1  sticky: req_fire seen on a port whose count is saturated
err_late_req  output  1  sticky: req_fire seen while in IDLE
drain_timeout  output  1  sticky: drain_limit reached before IDLE

Behaviour:
- Reset (async assert, sync deassert by the environment) sets:
  - all counters 0, state RUN, quiet_cnt 0, drain_cnt 0
  - all outputs 0, including idle=0 and outstanding_total=0
- Per-port counter, updated every edge in every state:
  - req only: +1. If already at max, hold the value and set err_overflow.
  - rsp only: -1. If already at 0, hold at 0 and set err_underflow.
  - req and rsp on the same port in the same cycle: count unchanged, no error, even when the count is 0 or max.
- all_zero: combinational, true when every counter is 0. quiet: all_zero and no bit set in req_fire or rsp_fire this cycle.
- FSM:
  - RUN: when quit_req=1, go to DRAIN at the next edge.
  - DRAIN: drain_cnt increments each edge. When quiet, go to QUIET and clear quiet_cnt.
  - QUIET: any fire goes back to DRAIN. Otherwise quiet_cnt+1 each edge; at the edge where quiet_cnt==QUIET_CYCLES-1 and quiet holds, go to IDLE.
  - IDLE: sticky. A req_fire sets err_late_req and returns the FSM to DRAIN; the counters still update. A rsp_fire alone in IDLE sets err_underflow via the counter rule and leaves the state unchanged.
- idle latency: idle goes high after edge E0+QUIET_CYCLES, where E0 is the DRAIN->QUIET edge. It drops at the edge that leaves IDLE.
- drain_cnt:
  - counts edges spent in DRAIN or QUIET; it is not cleared when moving between those two states.
  - when drain_limit!=0 and drain_cnt==drain_limit, set drain_timeout. The FSM keeps running.
  - drain_cnt saturates at its maximum value.
- quit_req is ignored outside RUN. A quit pulse of one cycle is sufficient.
- outstanding_total: registered, reflects the counter values after the same edge.
- Reset mid-operation: everything returns to its reset values immediately (async). Traffic in flight at that point is not tracked.

Decomposition:
- Package t1_idle_pkg holds:
  - enum state_e {RUN, DRAIN, QUIET, IDLE}, 2 bits
  - the localparam expression for the outstanding_total width
- Sub-module t1_outstanding_counter (parameter CNT_W): one saturating up/down counter with req/rsp inputs and overflow/underflow pulse outputs. It is instantiated NUM_PORTS times by a generate loop.
- The top level contains the FSM, quiet_cnt, drain_cnt, the sum and the sticky error registers.

Test Plan:
- QUIET_CYCLES=4, all counters 0, 1-cycle quit_req at cycle 10 -> DRAIN after edge 11, QUIET after edge 12, idle=1 after edge 16; no error bits set.
- Port0: 3 req_fire, then quit_req, then 3 rsp_fire spaced 5 cycles apart -> outstanding_total steps 3,2,1,0; idle rises exactly QUIET_CYCLES+1 edges after the edge that zeroes the count.
- Port1 count=0, req_fire and rsp_fire in the same cycle -> count stays 0, err_underflow=0. rsp_fire alone on port1 -> err_underflow=1, count stays 0.
- CNT_W=2: 4 req_fire on port2 -> count 3, err_overflow=1. Next 3 rsp_fire -> count 0.
- Machine in IDLE, req_fire on port0 -> idle=0 next edge, err_late_req=1, state DRAIN. Matching rsp_fire plus QUIET_CYCLES quiet cycles -> idle=1 again.
- drain_limit=20, port0 holding 1 outstanding forever after quit_req -> drain_timeout=1 exactly 20 edges after entering DRAIN; idle stays 0. Assert reset_n mid-run -> all outputs 0 asynchronously.
